// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, frame
// geometry and the transmit state encoding.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 10;

    localparam logic [3:0] UART_REG_TX   = 4'h0;
    localparam logic [3:0] UART_REG_RX   = 4'h4;
    localparam logic [3:0] UART_REG_CTRL = 4'h8;
    localparam logic [3:0] UART_REG_BAUD = 4'hC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO shared by the UART transmit and receive paths.
// No bypass: a word pushed into an empty FIFO becomes poppable next cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count < DEPTH_C) || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)
                count <= count + CW'(1);
            else if (pop_ok && !push_ok)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    // Full one entry early so a write already in flight through the LSU still lands.
    assign full    = (count >= DEPTH_C - CW'(1));
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes written by the LSU and shifts them out as
// 8N1 frames at a bit period of max(brd,1) clk cycles, latched per frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] uart_in,
    input  logic                   busy,
    input  logic [15:0]            brd,
    output logic                   Ff,
    output logic                   Fe,
    output logic                   tx_active,
    output logic                   tx,
    output tx_state_e              state_dbg
);

    localparam int CW = $clog2(DEPTH) + 1;

    // busy is a write strobe with no ready: the byte is taken when it fits,
    // otherwise dropped; the LSU throttles itself on the registered Ff.
    tx_state_e              state;
    logic [UART_DATA_W-1:0] shreg;
    logic [15:0]            bit_len;
    logic [15:0]            baud_cnt;
    logic [2:0]             bit_cnt;
    logic                   tx_q;
    logic                   pop;
    logic                   bit_end;
    logic [UART_DATA_W-1:0] head;
    logic [CW-1:0]          fifo_count;

    uart_sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (busy),
        .pop     (pop),
        .wr_data (uart_in),
        .rd_data (head),
        .count   (fifo_count),
        .full    (Ff),
        .empty   (Fe)
    );

    assign pop     = (state == IDLE) && (fifo_count != '0);
    assign bit_end = (baud_cnt == bit_len - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_len  <= 16'd1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shreg    <= head;
                        bit_len  <= (brd == 16'd0) ? 16'd1 : brd;
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        tx_q     <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_q     <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shreg    <= {1'b0, shreg[UART_DATA_W-1:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx_q <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx        = tx_q;
    assign tx_active = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed plus randomized bench for uart_tx: a line monitor decodes frames
// against expected bit lengths, and a scoreboard compares bytes in order.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  uart_in;
    logic        busy;
    logic [15:0] brd;
    logic        Ff;
    logic        Fe;
    logic        tx_active;
    logic        tx;
    tx_state_e   state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         exp_len_q[$];
    int         mon_err = 0;

    uart_tx #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_in   (uart_in),
        .busy      (busy),
        .brd       (brd),
        .Ff        (Ff),
        .Fe        (Fe),
        .tx_active (tx_active),
        .tx        (tx),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input int bl, input bit expect_tx);
        busy    = 1'b1;
        uart_in = b;
        if (expect_tx) begin
            exp_q.push_back(b);
            exp_len_q.push_back(bl);
        end
        step();
        busy = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n);
        for (int i = 0; i < 3000; i++) begin
            if (rx_q.size() >= n) break;
            step();
        end
        chk(tag, rx_q.size(), n);
    endtask

    task automatic score(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0)
            chk({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
        chk({tag, "_mon"}, mon_err, 0);
        exp_q.delete();
        rx_q.delete();
    endtask

    // Line monitor: decodes frames, checks each bit level holds for its full
    // period, a valid start/stop, and at least one idle-high cycle between frames.
    initial begin
        int busy_m = 0, bit_i = 0, cyc = 0, len = 1, need_gap = 0;
        logic lvl;
        logic [9:0] bits;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_m = 0; need_gap = 0; cyc = 0; bit_i = 0;
            end else begin
                if (!busy_m) begin
                    if (need_gap) begin
                        if (tx !== 1'b1) mon_err++;
                        need_gap = 0;
                    end else if (tx === 1'b0) begin
                        busy_m = 1; bit_i = 0; cyc = 0;
                        if (exp_len_q.size() > 0) len = exp_len_q.pop_front();
                        else begin mon_err++; len = 1; end
                    end
                end
                if (busy_m) begin
                    if (cyc == 0) lvl = tx;
                    else if (tx !== lvl) mon_err++;
                    cyc++;
                    if (cyc == len) begin
                        bits[bit_i] = lvl;
                        cyc = 0;
                        bit_i++;
                        if (bit_i == UART_FRAME_BITS) begin
                            if (bits[0] !== 1'b0 || bits[9] !== 1'b1) mon_err++;
                            rx_q.push_back(bits[8:1]);
                            busy_m = 0;
                            need_gap = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int m_count, m_free, bl, n;
        bit do_pop, acc;
        rst_n = 1'b0; busy = 1'b0; uart_in = '0; brd = 16'd1;
        step(3);
        rst_n = 1'b1;

        // 1: reset state held while idle
        for (int i = 0; i < 20; i++) begin
            chk("idle", {tx, Fe, Ff, tx_active}, 4'b1100);
            step();
        end

        // 2: brd=4, 0x55, latency and frame timing
        brd = 16'd4;
        push_byte(8'h55, 4, 1);
        chk("lat_c1_tx", tx, 1'b1);
        chk("lat_c1_fe", Fe, 1'b0);
        step();
        chk("lat_c2_tx", tx, 1'b0);
        chk("lat_c2_act", tx_active, 1'b1);
        step(39);
        chk("c41_act", tx_active, 1'b1);
        step();
        chk("c42_idle", {tx, tx_active, Fe}, 3'b101);
        wait_rx("t2_rx", 1);
        score("t2");

        // 3: brd=0 treated as 1
        brd = 16'd0;
        push_byte(8'hA3, 1, 1);
        wait_rx("t3_rx", 1);
        score("t3");
        step(5);

        // 4: burst of 10 at brd=2, model tracks occupancy and pop times
        bl = 2; brd = 16'd2;
        m_count = 0; m_free = 0;
        for (int c = 0; c < 10; c++) begin
            chk("burst_ff", Ff, (m_count >= DEPTH - 1));
            chk("burst_fe", Fe, (m_count == 0));
            acc    = (m_count < DEPTH);
            do_pop = (m_count > 0) && (c >= m_free);
            if (do_pop) begin
                m_count--;
                m_free = c + 10 * bl + 1;
            end
            acc = acc || do_pop;
            busy = 1'b1; uart_in = 8'(c);
            if (acc) begin
                m_count++;
                exp_q.push_back(8'(c));
                exp_len_q.push_back(bl);
            end
            step();
        end
        busy = 1'b0;
        chk("burst_ff_end", Ff, (m_count >= DEPTH - 1));
        wait_rx("t4_rx", exp_q.size());
        step(30);
        score("t4");

        // 5: brd change mid-frame applies only to the next frame
        brd = 16'd3;
        push_byte(8'h0F, 3, 1);
        step(6);
        chk("t5_in_data", state_dbg, DATA);
        brd = 16'd8;
        push_byte(8'hF0, 8, 1);
        wait_rx("t5_rx", 2);
        score("t5");

        // randomized rounds with brd set only while idle
        for (int r = 0; r < 4; r++) begin
            bl = $urandom_range(0, 5);
            brd = 16'(bl);
            if (bl == 0) bl = 1;
            n = $urandom_range(1, DEPTH - 2);
            for (int k = 0; k < n; k++) push_byte(8'($urandom_range(0, 255)), bl, 1);
            wait_rx("rand_rx", n);
            step(3);
            score("rand");
        end

        // 6: reset mid-DATA aborts and discards the FIFO
        brd = 16'd4;
        push_byte(8'h00, 4, 1);
        push_byte(8'h81, 4, 1);
        step(10);
        chk("t6_in_data", state_dbg, DATA);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_tx", tx, 1'b1);
        chk("t6_rst_fe", Fe, 1'b1);
        chk("t6_rst_act", tx_active, 1'b0);
        exp_q.delete(); exp_len_q.delete(); rx_q.delete();
        step(3);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            chk("t6_quiet", {tx, Fe}, 2'b11);
            step();
        end
        chk("t6_no_frame", rx_q.size(), 0);
        chk("t6_mon", mon_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
